uart_fifo_bridge: RTL and testbench
===================================

# uart_fifo_bridge

Parametrised successor to the single-byte UART echo buffer on the thinpad top level. It places a configurable-depth RX FIFO and TX FIFO between `async_receiver`/`async_transmitter` and a CPU-side byte interface. It also provides sticky overflow flags, occupancy counts, and an optional hardware loopback (echo) mode. It sits on the `clk_50M` domain next to `CPU_top`, which will use it as its serial port.

## Interface
- `RX_DEPTH_LOG2`, default 4: RX FIFO depth = 2^RX_DEPTH_LOG2 bytes (legal 1..8).
- `TX_DEPTH_LOG2`, default 4: TX FIFO depth = 2^TX_DEPTH_LOG2 bytes (legal 1..8).
- `LOOPBACK`, default 0: when 1, received bytes go to the TX FIFO instead of the RX FIFO, and CPU writes are ignored.

Ports:
- `clk` in 1: single clock (50 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `rx_data_ready` in 1: byte-available flag from `async_receiver`.
- `rx_data` in 8: received byte.
- `rx_clear` out 1: clear to `async_receiver`; combinational copy of `rx_data_ready`.
- `tx_busy` in 1: `async_transmitter` busy.
- `tx_start` out 1: registered one-cycle start pulse.
- `tx_data` out 8: registered byte to transmit.
- `rd_en` in 1: CPU pops the RX head.
- `rd_data` out 8: RX head byte (first-word fall-through); valid when `rx_valid`.
- `rx_valid` out 1: RX FIFO not empty.
- `wr_en` in 1: CPU pushes `wr_data` into the TX FIFO.
- `wr_data` in 8: byte to send.
- `tx_ready` out 1: TX FIFO not full.
- `rx_count` out RX_DEPTH_LOG2+1: RX occupancy.
- `tx_count` out TX_DEPTH_LOG2+1: TX occupancy.
- `rx_overflow` out 1: sticky; set when a received byte is dropped.
- `tx_overflow` out 1: sticky; set when a CPU write is dropped.
- `clr_overflow` in 1: clears both sticky flags.

## Operation
- **Reset values:** all pointers and counts 0, `rx_valid`=0, `tx_ready`=1, `tx_start`=0, `tx_data`=0, both overflow flags 0, TX FSM in IDLE. `rd_data` is don't-care while empty.
- **RX push:** on a cycle with `rx_data_ready`=1, the byte is pushed into the target FIFO.
  - Target is the RX FIFO, or the TX FIFO when LOOPBACK=1.
  - If the target is full and no pop happens that cycle, the byte is dropped and the matching overflow flag is set (`rx_overflow` for the RX FIFO, `tx_overflow` for the TX FIFO).
- **RX pop:** `rd_en` with `rx_valid`=1 advances the head. `rd_en` while empty is ignored.
- **TX push:** `wr_en` with the TX FIFO not full pushes `wr_data`.
  - `wr_en` while full drops the byte and sets `tx_overflow`.
  - When LOOPBACK=1, `wr_en` is ignored entirely and no flag is set.
- **Simultaneous push and pop on one FIFO:** both take effect and the count is unchanged. This includes the full case: the push is accepted and no overflow is flagged.
- **Overflow flags:** `clr_overflow` takes priority over a same-cycle set, so the flag reads 0 afterwards.
- **TX FSM**, states IDLE, START, GUARD:
  - IDLE: when the TX FIFO is non-empty and `tx_busy`=0, pop the head into `tx_data`, register `tx_start`=1, and go to START.
  - START: `tx_start` is high this cycle; go to GUARD and drive `tx_start`=0.
  - GUARD: wait one cycle so the transmitter can raise `tx_busy`, then return to IDLE.
  - IDLE re-tests `tx_busy` before issuing the next byte.
- **Pointers:** pointers are DEPTH_LOG2 bits and wrap modulo depth. Full and empty are derived from the count.

## Timing
- RX byte to `rx_valid`: 1 cycle after the `rx_data_ready` edge is sampled. `rd_data` is valid in that same cycle.
- `rd_en` in cycle N: the next byte appears on `rd_data` in cycle N+1. `rx_count` updates at N+1.
- TX: with `wr_en` in cycle N into an empty FIFO and `tx_busy`=0, the FSM sees non-empty at N+1 and `tx_start`=1 during N+2. `tx_data` is stable from N+2 until the next pop.
- Minimum spacing between `tx_start` pulses is 3 cycles; actual spacing is governed by `tx_busy`.
- Loopback latency: `rx_data_ready` at N gives `tx_start` at N+2, given an idle transmitter.
- An asynchronous `reset` mid-operation immediately drops `tx_start` and empties both FIFOs. The in-flight transmitter byte is not tracked.

## Test plan
- **RX fill, default depth 16:** inject 17 bytes 0x00..0x10 with CPU idle -> `rx_count`=16, `rx_overflow`=1; pops return 0x00..0x0F; byte 0x10 is lost.
- **CPU TX:** write 0x55, 0xAA with a `tx_busy` model holding for 20 cycles after each start -> exactly two `tx_start` pulses, `tx_data` 0x55 then 0xAA, and the second pulse no earlier than busy fall + 1.
- **Simultaneous full push and pop:** with the RX FIFO full, issue `rx_data_ready` and `rd_en` in the same cycle -> `rx_count` stays 16, `rx_overflow` stays 0, and the new byte is last in order.
- **LOOPBACK=1:** inject 0x41, 0x42 and assert `wr_en` with 0x99 -> transmits 0x41 then 0x42; 0x99 never appears; `rx_valid` stays 0; `tx_overflow`=0.
- **Pointer wrap:** push and pop 40 bytes with RX_DEPTH_LOG2=2 at random rates, keeping occupancy at or below 4 -> output order matches input with no overflow.
- **Reset mid-transmit:** assert `reset` during START with 3 bytes queued -> `tx_start`=0 in the same cycle, counts 0, flags 0; after release, no `tx_start` occurs until a new write.

Source files
------------

// File: rtl/uart_fifo_bridge_if.sv
// Bus bundle between the UART bridge and its surroundings: receiver/transmitter
// strobes, the CPU byte port, status counts and a debug view of the TX FSM.
interface uart_fifo_bridge_if #(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4
);
    // Handshakes: a byte moves on any cycle its strobe is high at the clock
    // edge (rx_data_ready, rd_en with rx_valid, wr_en with tx_ready); the
    // transmitter accepts tx_data on the single-cycle tx_start pulse when
    // tx_busy is low.
    logic                   rx_data_ready;
    logic [7:0]             rx_data;
    logic                   rx_clear;
    logic                   tx_busy;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic                   rd_en;
    logic [7:0]             rd_data;
    logic                   rx_valid;
    logic                   wr_en;
    logic [7:0]             wr_data;
    logic                   tx_ready;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic                   rx_overflow;
    logic                   tx_overflow;
    logic                   clr_overflow;
    logic [1:0]             tx_state;

    modport master (
        output rx_data_ready, rx_data, tx_busy, rd_en, wr_en, wr_data, clr_overflow,
        input  rx_clear, tx_start, tx_data, rd_data, rx_valid, tx_ready,
               rx_count, tx_count, rx_overflow, tx_overflow, tx_state
    );

    modport slave (
        input  rx_data_ready, rx_data, tx_busy, rd_en, wr_en, wr_data, clr_overflow,
        output rx_clear, tx_start, tx_data, rd_data, rx_valid, tx_ready,
               rx_count, tx_count, rx_overflow, tx_overflow, tx_state
    );
endinterface

// File: rtl/uart_fifo_bridge.sv
// RX and TX byte FIFOs between the UART receiver/transmitter and the CPU,
// with sticky overflow flags, occupancy counts and an optional echo mode.
module uart_fifo_bridge #(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter bit LOOPBACK      = 1'b0
) (
    input logic               clk,
    input logic               reset,
    uart_fifo_bridge_if.slave bus
);
    localparam int RX_AW    = RX_DEPTH_LOG2;
    localparam int TX_AW    = TX_DEPTH_LOG2;
    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;

    localparam logic [RX_AW:0]   RX_FULL    = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0]   TX_FULL    = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0]   RX_CNT_ONE = (RX_AW + 1)'(1);
    localparam logic [TX_AW:0]   TX_CNT_ONE = (TX_AW + 1)'(1);
    localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
    localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        GUARD = 2'd2
    } tx_state_t;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr;
    logic [RX_AW-1:0] rx_rd_ptr;
    logic [RX_AW:0]   rx_cnt;
    logic             rx_req;
    logic             rx_full;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_drop;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr;
    logic [TX_AW-1:0] tx_rd_ptr;
    logic [TX_AW:0]   tx_cnt;
    logic             tx_req;
    logic [7:0]       tx_din;
    logic             tx_full;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_drop;

    logic             rx_ovf_q;
    logic             tx_ovf_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    tx_state_t        state_q;
    tx_state_t        state_d;

    // In echo mode the receiver feeds the TX FIFO and CPU writes are ignored.
    assign rx_req = bus.rx_data_ready && !LOOPBACK;
    assign tx_req = LOOPBACK ? bus.rx_data_ready : bus.wr_en;
    assign tx_din = LOOPBACK ? bus.rx_data : bus.wr_data;

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign rx_full = (rx_cnt == RX_FULL);
    assign rx_pop  = bus.rd_en && (rx_cnt != '0);
    assign rx_push = rx_req && (!rx_full || rx_pop);
    assign rx_drop = rx_req && rx_full && !rx_pop;

    assign tx_full = (tx_cnt == TX_FULL);
    assign tx_push = tx_req && (!tx_full || tx_pop);
    assign tx_drop = tx_req && tx_full && !tx_pop;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + RX_CNT_ONE;
                2'b01:   rx_cnt <= rx_cnt - RX_CNT_ONE;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + TX_CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - TX_CNT_ONE;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // Clearing wins over a drop in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else if (bus.clr_overflow) begin
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else begin
            if (rx_drop) begin
                rx_ovf_q <= 1'b1;
            end
            if (tx_drop) begin
                tx_ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // GUARD gives the transmitter a cycle to raise tx_busy before IDLE re-tests it.
    always_comb begin
        state_d = state_q;
        tx_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if ((tx_cnt != '0) && !bus.tx_busy) begin
                    tx_pop  = 1'b1;
                    state_d = START;
                end
            end
            START:   state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_start_q <= tx_pop;
            if (tx_pop) begin
                tx_data_q <= tx_mem[tx_rd_ptr];
            end
        end
    end

    assign bus.rx_clear    = bus.rx_data_ready;
    assign bus.rd_data     = rx_mem[rx_rd_ptr];
    assign bus.rx_valid    = (rx_cnt != '0);
    assign bus.tx_ready    = !tx_full;
    assign bus.rx_count    = rx_cnt;
    assign bus.tx_count    = tx_cnt;
    assign bus.rx_overflow = rx_ovf_q;
    assign bus.tx_overflow = tx_ovf_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_state    = state_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: default build, a 4-deep RX build and an echo build,
// with queue-based scoreboards checked by monitors on the DUT outputs.
module tb_uart_fifo_bridge;
    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;

    uart_fifo_bridge_if #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) b0 ();
    uart_fifo_bridge_if #(.RX_DEPTH_LOG2(2), .TX_DEPTH_LOG2(4)) b1 ();
    uart_fifo_bridge_if #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) b2 ();

    uart_fifo_bridge #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4), .LOOPBACK(1'b0)) u0 (
        .clk(clk), .reset(reset), .bus(b0));
    uart_fifo_bridge #(.RX_DEPTH_LOG2(2), .TX_DEPTH_LOG2(4), .LOOPBACK(1'b0)) u1 (
        .clk(clk), .reset(reset), .bus(b1));
    uart_fifo_bridge #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4), .LOOPBACK(1'b1)) u2 (
        .clk(clk), .reset(reset), .bus(b2));

    logic [7:0] exp_rx0[$];
    logic [7:0] exp_tx0[$];
    logic [7:0] exp_rx1[$];
    logic [7:0] exp_tx2[$];

    int   tx0_pulses;
    int   tx2_pulses;
    int   rx1_got;
    int   last_start0;
    int   fall_cyc0;
    int   first_start2;
    bit   rx_valid_seen2;
    logic busy_hold0;
    logic busy_model0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- busy model for u0 ----------------
    assign b0.tx_busy = busy_hold0 | busy_model0;

    initial begin
        busy_model0 = 1'b0;
        fall_cyc0   = 0;
        forever begin
            @(negedge clk);
            if (b0.tx_start) begin
                busy_model0 = 1'b1;
                repeat (20) @(negedge clk);
                busy_model0 = 1'b0;
                fall_cyc0   = cyc;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got 0x%0h, expected no output", name, act);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!reset && b0.rd_en && b0.rx_valid) begin
            if (exp_rx0.size() == 0) unexpected("rx0_data", int'(b0.rd_data));
            else check("rx0_data", int'(b0.rd_data), int'(exp_rx0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!reset && b1.rd_en && b1.rx_valid) begin
            rx1_got++;
            if (exp_rx1.size() == 0) unexpected("rx1_data", int'(b1.rd_data));
            else check("rx1_data", int'(b1.rd_data), int'(exp_rx1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (b0.tx_start) begin
            tx0_pulses++;
            last_start0 = cyc;
            if (exp_tx0.size() == 0) unexpected("tx0_data", int'(b0.tx_data));
            else check("tx0_data", int'(b0.tx_data), int'(exp_tx0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (b2.rx_valid) rx_valid_seen2 = 1'b1;
        if (b2.tx_start) begin
            if (tx2_pulses == 0) first_start2 = cyc;
            tx2_pulses++;
            if (exp_tx2.size() == 0) unexpected("tx2_data", int'(b2.tx_data));
            else check("tx2_data", int'(b2.tx_data), int'(exp_tx2.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx0_inject(input logic [7:0] d);
        b0.rx_data_ready = 1'b1;
        b0.rx_data       = d;
        step();
        b0.rx_data_ready = 1'b0;
    endtask

    task automatic rx0_drain(input int n);
        b0.rd_en = 1'b1;
        repeat (n) step();
        b0.rd_en = 1'b0;
    endtask

    task automatic tx0_write(input logic [7:0] d);
        b0.wr_en   = 1'b1;
        b0.wr_data = d;
        step();
        b0.wr_en   = 1'b0;
    endtask

    task automatic clear_flags0();
        b0.clr_overflow = 1'b1;
        step();
        b0.clr_overflow = 1'b0;
    endtask

    task automatic run_wrap();
        bit         do_push;
        bit         do_pop;
        int         sent;
        int         occ;
        int         guard;
        logic [7:0] d;
        sent  = 0;
        occ   = 0;
        guard = 0;
        while ((sent < 40 || occ > 0) && guard < 2000) begin
            do_pop  = (occ > 0) && ($urandom_range(0, 1) == 1);
            do_push = (sent < 40) && (occ < 4 || do_pop) && ($urandom_range(0, 2) != 0);
            d       = 8'(sent * 7 + 3);
            b1.rx_data_ready = do_push;
            b1.rx_data       = d;
            b1.rd_en         = do_pop;
            if (do_push) begin
                exp_rx1.push_back(d);
                sent++;
                occ++;
            end
            if (do_pop) occ--;
            step();
            guard++;
        end
        b1.rx_data_ready = 1'b0;
        b1.rd_en         = 1'b0;
        check("wrap_sent", sent, 40);
    endtask

    task automatic wait_tx0_empty(input string name, input int limit);
        int k;
        k = 0;
        while (exp_tx0.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_tx0.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int k;
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        tx0_pulses = 0;
        tx2_pulses = 0;
        rx1_got = 0;
        last_start0 = 0;
        first_start2 = 0;
        rx_valid_seen2 = 1'b0;
        busy_hold0 = 1'b0;
        reset = 1'b1;
        b0.rx_data_ready = 1'b0; b0.rx_data = 8'h00; b0.rd_en = 1'b0;
        b0.wr_en = 1'b0; b0.wr_data = 8'h00; b0.clr_overflow = 1'b0;
        b1.rx_data_ready = 1'b0; b1.rx_data = 8'h00; b1.rd_en = 1'b0; b1.tx_busy = 1'b0;
        b1.wr_en = 1'b0; b1.wr_data = 8'h00; b1.clr_overflow = 1'b0;
        b2.rx_data_ready = 1'b0; b2.rx_data = 8'h00; b2.rd_en = 1'b0; b2.tx_busy = 1'b0;
        b2.wr_en = 1'b0; b2.wr_data = 8'h00; b2.clr_overflow = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // reset values
        check("reset_rx_valid", int'(b0.rx_valid), 0);
        check("reset_tx_ready", int'(b0.tx_ready), 1);
        check("reset_tx_start", int'(b0.tx_start), 0);
        check("reset_tx_data", int'(b0.tx_data), 0);
        check("reset_rx_count", int'(b0.rx_count), 0);
        check("reset_tx_count", int'(b0.tx_count), 0);
        check("reset_overflow", int'({b0.rx_overflow, b0.tx_overflow}), 0);
        check("reset_tx_state", int'(b0.tx_state), 0);
        check("reset_rx1_count", int'(b1.rx_count), 0);

        // RX fill past capacity: 0x10 is dropped
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_rx0.push_back(8'(i));
            rx0_inject(8'(i));
        end
        check("fill_rx_count", int'(b0.rx_count), 16);
        check("fill_rx_overflow", int'(b0.rx_overflow), 1);
        check("fill_rx_valid", int'(b0.rx_valid), 1);
        check("fill_tx_overflow", int'(b0.tx_overflow), 0);
        rx0_drain(16);
        check("drain_rx_count", int'(b0.rx_count), 0);
        check("drain_rx_valid", int'(b0.rx_valid), 0);
        check("drain_leftover", exp_rx0.size(), 0);
        rx0_drain(2);
        check("empty_pop_count", int'(b0.rx_count), 0);
        clear_flags0();
        check("clr_rx_overflow", int'(b0.rx_overflow), 0);

        // simultaneous push and pop on a full RX FIFO
        for (int i = 0; i < 16; i++) begin
            exp_rx0.push_back(8'(8'h20 + i));
            rx0_inject(8'(8'h20 + i));
        end
        check("full_rx_count", int'(b0.rx_count), 16);
        exp_rx0.push_back(8'h30);
        b0.rx_data_ready = 1'b1;
        b0.rx_data       = 8'h30;
        b0.rd_en         = 1'b1;
        step();
        b0.rx_data_ready = 1'b0;
        b0.rd_en         = 1'b0;
        check("simul_rx_count", int'(b0.rx_count), 16);
        check("simul_rx_overflow", int'(b0.rx_overflow), 0);
        rx0_drain(16);
        check("simul_leftover", exp_rx0.size(), 0);
        check("simul_rx_count_end", int'(b0.rx_count), 0);

        // pointer wrap on the 4-deep build
        run_wrap();
        check("wrap_got", rx1_got, 40);
        check("wrap_leftover", exp_rx1.size(), 0);
        check("wrap_rx_overflow", int'(b1.rx_overflow), 0);
        check("wrap_rx_count", int'(b1.rx_count), 0);

        // loopback: echo two bytes, CPU write ignored
        exp_tx2.push_back(8'h41);
        exp_tx2.push_back(8'h42);
        p = cyc;
        b2.rx_data_ready = 1'b1;
        b2.rx_data       = 8'h41;
        step();
        b2.rx_data       = 8'h42;
        step();
        b2.rx_data_ready = 1'b0;
        b2.wr_en         = 1'b1;
        b2.wr_data       = 8'h99;
        step();
        b2.wr_en         = 1'b0;
        repeat (30) step();
        check("loop_pulses", tx2_pulses, 2);
        check("loop_latency", first_start2 - p, 2);
        check("loop_rx_valid_seen", int'(rx_valid_seen2), 0);
        check("loop_tx_overflow", int'(b2.tx_overflow), 0);
        check("loop_tx_count", int'(b2.tx_count), 0);
        check("loop_rx_count", int'(b2.rx_count), 0);

        // CPU TX with a busy transmitter
        exp_tx0.push_back(8'h55);
        exp_tx0.push_back(8'hAA);
        tx0_write(8'h55);
        tx0_write(8'hAA);
        k = 0;
        while (tx0_pulses < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cpu_tx_pulses", tx0_pulses, 2);
        check("cpu_tx_restart", last_start0 - fall_cyc0, 1);
        #1;
        check("cpu_tx_data_hold", int'(b0.tx_data), 8'hAA);
        check("cpu_tx_overflow", int'(b0.tx_overflow), 0);
        repeat (25) step();
        check("cpu_tx_pulses_final", tx0_pulses, 2);

        // TX overflow and clear-over-set priority
        busy_hold0 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_tx0.push_back(8'(8'h60 + i));
            tx0_write(8'(8'h60 + i));
        end
        check("txfull_count", int'(b0.tx_count), 16);
        check("txfull_ready", int'(b0.tx_ready), 0);
        check("txfull_overflow", int'(b0.tx_overflow), 1);
        check("txfull_rx_overflow", int'(b0.rx_overflow), 0);
        b0.wr_en        = 1'b1;
        b0.wr_data      = 8'h7F;
        b0.clr_overflow = 1'b1;
        step();
        b0.wr_en        = 1'b0;
        b0.clr_overflow = 1'b0;
        check("clr_priority_overflow", int'(b0.tx_overflow), 0);
        check("clr_priority_count", int'(b0.tx_count), 16);
        busy_hold0 = 1'b0;
        wait_tx0_empty("txfull_drain", 1000);
        repeat (30) step();

        // reset during START with bytes queued
        busy_hold0 = 1'b1;
        for (int i = 0; i < 17; i++) rx0_inject(8'(8'h80 + i));
        check("pre_reset_rx_overflow", int'(b0.rx_overflow), 1);
        exp_tx0.push_back(8'h71);
        exp_tx0.push_back(8'h72);
        exp_tx0.push_back(8'h73);
        tx0_write(8'h71);
        tx0_write(8'h72);
        tx0_write(8'h73);
        busy_hold0 = 1'b0;
        k = 0;
        while (b0.tx_start !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pre_reset_start_seen", int'(b0.tx_start), 1);
        #2;
        reset = 1'b1;
        #1;
        check("reset_mid_tx_start", int'(b0.tx_start), 0);
        check("reset_mid_rx_count", int'(b0.rx_count), 0);
        check("reset_mid_tx_count", int'(b0.tx_count), 0);
        check("reset_mid_flags", int'({b0.rx_overflow, b0.tx_overflow}), 0);
        check("reset_mid_tx_state", int'(b0.tx_state), 0);
        exp_tx0.delete();
        p = tx0_pulses;
        repeat (2) step();
        reset = 1'b0;
        repeat (40) step();
        check("post_reset_no_start", tx0_pulses - p, 0);
        exp_tx0.push_back(8'h7E);
        tx0_write(8'h7E);
        wait_tx0_empty("post_reset_write", 60);
        check("post_reset_pulse", tx0_pulses - p, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
